instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Consumer end of the instruction fetch interface. Accepts 16-bit instruction words plus their PC from the fetch unit over a valid/ready handshake and decodes them into fields. Issues decoded fields downstream through a 2-entry skid buffer, and returns a one-cycle redirect (jump target) to the fetch unit. Halts the front end on HLT.

Parameters:
- PC_W, 16, PC / redirect target width
- IW, 16, instruction width; the field map below is fixed for 16

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_valid  in  1  fetch presents a word
- if_instr  in  16  instruction word
- if_pc  in  PC_W  PC of if_instr
- if_ready  out  1  decode can accept (registered)
- id_valid  out  1  decoded entry valid
- id_ready  in  1  downstream accepts
- id_opcode  out  4  instr[15:12]
- id_rd  out  4  instr[11:8]
- id_rs  out  4  instr[7:4]
- id_rt  out  4  instr[3:0]
- id_imm  out  16  sign-extended immediate, per opcode
- id_pc  out  PC_W  PC of the entry
- id_illegal  out  1  opcode is undefined
- redirect_valid  out  1  one-cycle pulse to fetch
- redirect_pc  out  PC_W  jump target
- halt  out  1  front end stopped

Behaviour:
- Reset (rst=0 at clk edge):
  - if_ready=1, id_valid=0, all id_* fields=0, redirect_valid=0, redirect_pc=0, halt=0.
  - Both buffer entries empty; state=RUN.
  - A reset mid-transfer discards all buffered entries.
- Transfer rules:
  - An input is accepted when if_valid & if_ready.
  - An output is consumed when id_valid & id_ready.
  - id_* fields are stable while id_valid=1 and id_ready=0.
- Latency: a word accepted at edge N appears on id_* after edge N when the output slot is empty. Throughput is 1 per cycle when id_ready stays high.
- Skid buffer:
  - Output register plus one skid register; entries leave in order.
  - if_ready = NOT skid_full, registered.
  - If the output slot is occupied and not consumed, the accepted word goes to the skid register.
  - When the output is consumed, the skid entry moves to the output register.
  - Simultaneous accept and consume with an empty skid register: the new word goes directly to the output register.
- Decode map (opcode = instr[15:12]):
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR: id_imm=0.
  - 5 ADDI, 6 LD, 7 ST, 8 BEQ: id_imm = sign-extended instr[3:0].
  - C JMP: id_imm = sign-extended instr[11:0]. The target is resolved here.
  - F HLT.
  - 9, A, B, D, E: id_illegal=1, id_imm=0. The entry is still forwarded.
- State machine RUN / FLUSH / HALTED:
  - RUN: accepting JMP computes redirect_pc = if_pc + 1 + sext(instr[11:0]), mod 2^16 with wrap-around. redirect_valid=1 for exactly the next cycle; state goes to FLUSH. The JMP itself is forwarded downstream.
  - FLUSH (one cycle): if_ready is forced to 1. Any word presented that cycle is accepted and dropped (wrong path, never forwarded). Then return to RUN.
  - If the skid register is full when JMP is accepted, FLUSH waits: redirect_valid still pulses on the next cycle, but the drop cycle is the first cycle in which if_ready would be 1.
  - RUN: accepting HLT forwards it, then goes to HALTED.
  - HALTED: if_ready=0 and halt=1 until reset. Buffered entries still drain downstream.
  - JMP accepted while already in FLUSH: impossible, because FLUSH drops it.

Optional Feature:
- Macro: DECODE_STATS_EN
- Defined: adds outputs stat_issued[15:0] and stat_illegal[15:0].
  - stat_issued counts consumed entries.
  - stat_illegal counts consumed entries with id_illegal=1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports still present, tied to 0, no counter logic.

Test Plan:
- Stream 0x1123, 0x5A1F, 0x0000 with id_ready=1 held -> one output per cycle, first output the cycle after acceptance. 0x5A1F gives opcode 5, rd=A, rs=1, id_imm=16'hFFFF.
- id_ready=0 for 3 cycles while streaming -> output slot and skid register fill, if_ready=0 by the third word. No loss or reorder once id_ready=1.
- JMP 0xC010 at if_pc=0x0020, next word 0x1111 -> redirect_valid pulse with redirect_pc=0x0031. 0x1111 is dropped; the JMP entry is forwarded.
- JMP 0xCFFE at if_pc=0xFFFF -> redirect_pc=0xFFFE (wrap-around check).
- 0xD000 -> id_illegal=1. Then 0xF000 -> HLT forwarded, halt=1, if_ready=0 held for 10+ cycles.
- rst=0 asserted with both buffer entries full, then released -> id_valid=0, if_ready=1, halt=0. With DECODE_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decodes 16-bit fetch words into fields and issues them through a 2-entry skid buffer; JMP redirects fetch and HLT stops it. Ports: clk, rst (sync active-low); fetch side if_valid/if_instr/if_pc in, if_ready out; issue side id_valid/id_opcode/id_rd/id_rs/id_rt/id_imm/id_pc/id_illegal out, id_ready in; redirect_valid/redirect_pc/halt out; stat_issued/stat_illegal out (live only with DECODE_STATS_EN).
module instr_decode_stage #(
  parameter int PC_W = 16,
  parameter int IW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [IW-1:0]   if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [3:0]      id_opcode,
  output logic [3:0]      id_rd,
  output logic [3:0]      id_rs,
  output logic [3:0]      id_rt,
  output logic [15:0]     id_imm,
  output logic [PC_W-1:0] id_pc,
  output logic            id_illegal,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            halt,
  output logic [15:0]     stat_issued,
  output logic [15:0]     stat_illegal
);
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
  state_t state, state_n;
  logic [IW-1:0] out_instr, skid_instr;
  logic [PC_W-1:0] skid_pc, jmp_target;
  logic skid_valid, accept, push, pop, is_jmp, is_hlt, out_load, skid_load;
  logic id_valid_n, skid_valid_n;
  assign accept = if_valid & if_ready;
  // only RUN forwards; an accept during FLUSH is the dropped wrong-path word
  assign push = accept & (state == RUN);
  assign pop = id_valid & id_ready;
  assign is_jmp = push & (if_instr[15:12] == 4'hC);
  assign is_hlt = push & (if_instr[15:12] == 4'hF);
  // push only happens with an empty skid, since if_ready tracks !skid_valid
  assign out_load = push & (~id_valid | pop);
  assign skid_load = push & id_valid & ~pop;
  assign id_valid_n = (pop & skid_valid) | out_load | (id_valid & ~pop);
  assign skid_valid_n = skid_load | (skid_valid & ~pop);
  assign jmp_target = if_pc + PC_W'(1) + {{(PC_W-12){if_instr[11]}}, if_instr[11:0]};
  // a FLUSH entered with a full skid waits until if_ready rises, then drops one cycle
  always_comb begin
    state_n = state;
    if (state == RUN) state_n = is_jmp ? FLUSH : is_hlt ? HALTED : RUN;
    else if (state == FLUSH) state_n = if_ready ? RUN : FLUSH;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      if_ready <= 1'b1;
      id_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_instr <= '0;
      id_pc <= '0;
      skid_instr <= '0;
      skid_pc <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      if_ready <= (state_n != HALTED) & ~skid_valid_n;
      id_valid <= id_valid_n;
      skid_valid <= skid_valid_n;
      if (pop & skid_valid) begin
        out_instr <= skid_instr;
        id_pc <= skid_pc;
      end else if (out_load) begin
        out_instr <= if_instr;
        id_pc <= if_pc;
      end
      if (skid_load) begin
        skid_instr <= if_instr;
        skid_pc <= if_pc;
      end
      redirect_valid <= is_jmp;
      if (is_jmp) redirect_pc <= jmp_target;
    end
  end
  assign id_opcode = out_instr[15:12];
  assign id_rd = out_instr[11:8];
  assign id_rs = out_instr[7:4];
  assign id_rt = out_instr[3:0];
  assign id_illegal = id_opcode inside {4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
  assign id_imm = (id_opcode inside {4'h5, 4'h6, 4'h7, 4'h8}) ? {{12{out_instr[3]}}, out_instr[3:0]} :
                  (id_opcode == 4'hC) ? {{4{out_instr[11]}}, out_instr[11:0]} : 16'h0;
  assign halt = state == HALTED;
`ifdef DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_illegal <= '0;
    end else begin
      if (pop && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (pop && id_illegal && stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
    end
  end
`else
  assign stat_issued = '0;
  assign stat_illegal = '0;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed vector table plus hand-written sequences for instr_decode_stage.
module tb_instr_decode_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic if_valid = 1'b0, id_ready = 1'b0;
  logic [15:0] if_instr = '0, if_pc = '0;
  logic if_ready, id_valid, id_illegal, redirect_valid, halt;
  logic [3:0] id_opcode, id_rd, id_rs, id_rt;
  logic [15:0] id_imm, id_pc, redirect_pc, stat_issued, stat_illegal;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instr_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_pc(id_pc),
    .id_illegal(id_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .stat_issued(stat_issued), .stat_illegal(stat_illegal)
  );
  typedef struct {
    logic [15:0] instr;
    logic [15:0] fields;
    logic [15:0] imm;
    logic        ill;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vld, input logic [15:0] ins, input logic [15:0] pc, input logic rdy);
    if_valid = vld;
    if_instr = ins;
    if_pc = pc;
    id_ready = rdy;
  endtask
  task automatic chk_out(input string name, input logic [15:0] ins, input logic [15:0] pc);
    chk({name, "_valid"}, 32'(id_valid), 32'd1);
    chk({name, "_fields"}, {16'h0, id_opcode, id_rd, id_rs, id_rt}, {16'h0, ins});
    chk({name, "_pc"}, 32'(id_pc), 32'(pc));
  endtask
  initial begin
    v[0]  = '{16'h1123, 16'h1123, 16'h0000, 1'b0};
    v[1]  = '{16'h5A1F, 16'h5A1F, 16'hFFFF, 1'b0};
    v[2]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    v[3]  = '{16'h2345, 16'h2345, 16'h0000, 1'b0};
    v[4]  = '{16'h3456, 16'h3456, 16'h0000, 1'b0};
    v[5]  = '{16'h4567, 16'h4567, 16'h0000, 1'b0};
    v[6]  = '{16'h6008, 16'h6008, 16'hFFF8, 1'b0};
    v[7]  = '{16'h7007, 16'h7007, 16'h0007, 1'b0};
    v[8]  = '{16'h8F0F, 16'h8F0F, 16'hFFFF, 1'b0};
    v[9]  = '{16'h9ABC, 16'h9ABC, 16'h0000, 1'b1};
    v[10] = '{16'hA123, 16'hA123, 16'h0000, 1'b1};
    v[11] = '{16'hB7FF, 16'hB7FF, 16'h0000, 1'b1};
    v[12] = '{16'hD000, 16'hD000, 16'h0000, 1'b1};
    v[13] = '{16'hE5A5, 16'hE5A5, 16'h0000, 1'b1};
    tick;
    tick;
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_fields", {id_opcode, id_rd, id_rs, id_rt, id_imm}, 32'h0);
    chk("rst_misc", {id_pc, 13'h0, id_illegal, redirect_valid, halt}, 32'h0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'h0);
    rst = 1'b1;
    tick;
    // streaming decode, one output per cycle, visible right after the accepting edge
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, v[i].instr, 16'h0100 + 16'(i), 1'b1);
      chk($sformatf("stream_ready_%0d", i), 32'(if_ready), 32'd1);
      tick;
      chk_out($sformatf("vec%0d", i), v[i].fields, 16'h0100 + 16'(i));
      chk($sformatf("vec%0d_imm", i), 32'(id_imm), 32'(v[i].imm));
      chk($sformatf("vec%0d_ill", i), 32'(id_illegal), 32'(v[i].ill));
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    tick;
    chk("drain_valid", 32'(id_valid), 32'd0);
    // stall: output and skid fill, third word held back, order kept
    drive(1'b1, 16'h1AAA, 16'h0200, 1'b0);
    tick;
    chk_out("stall_a", 16'h1AAA, 16'h0200);
    drive(1'b1, 16'h2BBB, 16'h0201, 1'b0);
    tick;
    chk("stall_full_ready", 32'(if_ready), 32'd0);
    chk_out("stall_hold_a", 16'h1AAA, 16'h0200);
    drive(1'b1, 16'h3CCC, 16'h0202, 1'b0);
    tick;
    chk("stall_ready3", 32'(if_ready), 32'd0);
    chk_out("stall_hold_a2", 16'h1AAA, 16'h0200);
    drive(1'b1, 16'h3CCC, 16'h0202, 1'b1);
    tick;
    chk_out("stall_b", 16'h2BBB, 16'h0201);
    chk("stall_ready_back", 32'(if_ready), 32'd1);
    tick;
    chk_out("stall_c", 16'h3CCC, 16'h0202);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    tick;
    chk("stall_empty", 32'(id_valid), 32'd0);
    // JMP with flush drop
    drive(1'b1, 16'hC010, 16'h0020, 1'b1);
    tick;
    chk_out("jmp", 16'hC010, 16'h0020);
    chk("jmp_imm", 32'(id_imm), 32'h0010);
    chk("jmp_redir_v", 32'(redirect_valid), 32'd1);
    chk("jmp_redir_pc", 32'(redirect_pc), 32'h0031);
    chk("jmp_flush_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 16'h1111, 16'h0021, 1'b1);
    tick;
    chk("jmp_drop", 32'(id_valid), 32'd0);
    chk("jmp_pulse_end", 32'(redirect_valid), 32'd0);
    drive(1'b1, 16'h2222, 16'h0031, 1'b1);
    tick;
    chk_out("jmp_after", 16'h2222, 16'h0031);
    // wrap-around target
    drive(1'b1, 16'hCFFE, 16'hFFFF, 1'b1);
    tick;
    chk("wrap_redir_v", 32'(redirect_valid), 32'd1);
    chk("wrap_redir_pc", 32'(redirect_pc), 32'hFFFE);
    chk("wrap_imm", 32'(id_imm), 32'hFFFE);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    tick;
    chk("wrap_pulse_end", 32'(redirect_valid), 32'd0);
    // JMP lands in the skid: drop cycle waits for if_ready
    drive(1'b1, 16'h1000, 16'h0010, 1'b0);
    tick;
    drive(1'b1, 16'hC002, 16'h0011, 1'b0);
    tick;
    chk("dly_redir_v", 32'(redirect_valid), 32'd1);
    chk("dly_redir_pc", 32'(redirect_pc), 32'h0014);
    chk("dly_ready0", 32'(if_ready), 32'd0);
    drive(1'b1, 16'h1111, 16'h0012, 1'b0);
    tick;
    chk("dly_pulse_end", 32'(redirect_valid), 32'd0);
    chk_out("dly_hold", 16'h1000, 16'h0010);
    id_ready = 1'b1;
    tick;
    chk_out("dly_jmp_out", 16'hC002, 16'h0011);
    chk("dly_ready1", 32'(if_ready), 32'd1);
    tick;
    chk("dly_dropped", 32'(id_valid), 32'd0);
    drive(1'b1, 16'h2000, 16'h0014, 1'b1);
    tick;
    chk_out("dly_after", 16'h2000, 16'h0014);
    // HLT
    drive(1'b1, 16'hF000, 16'h0050, 1'b1);
    tick;
    chk_out("hlt", 16'hF000, 16'h0050);
    chk("hlt_halt", 32'(halt), 32'd1);
    drive(1'b1, 16'h1234, 16'h0051, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk($sformatf("halted_%0d", i), {29'h0, halt, if_ready, id_valid}, 32'b100);
    end
    // reset with both entries full
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick;
    rst = 1'b1;
    drive(1'b1, 16'h1001, 16'h0300, 1'b0);
    tick;
    drive(1'b1, 16'h1002, 16'h0301, 1'b0);
    tick;
    chk("full_before_rst", {30'h0, if_ready, id_valid}, 32'b01);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick;
    chk("midrst", {29'h0, if_ready, id_valid, halt}, 32'b100);
    chk("midrst_stats", {stat_issued, stat_illegal}, 32'h0);
    rst = 1'b1;
    id_ready = 1'b1;
    tick;
    chk("midrst_skid_gone", {30'h0, if_ready, id_valid}, 32'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
